// File: rtl/expansion_video_if.sv
// rtl/expansion_video_if.sv - pixel input and output stream bundle for the vertical 1:2 upscaler
interface expansion_video_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_pix;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_pix;
   logic             out_valid;
   logic             out_ready;
   logic             out_eol;
   logic             out_eof;

   modport slave (
      input  in_pix, in_valid, out_ready,
      output in_ready, out_pix, out_valid, out_eol, out_eof
   );

   modport master (
      output in_pix, in_valid, out_ready,
      input  in_ready, out_pix, out_valid, out_eol, out_eof
   );
endinterface

// File: rtl/expansion_video.sv
// rtl/expansion_video.sv - vertical 1:2 line upscaler: copy, interpolate and edge-duplicate lines
// Two ping-pong line buffers; a two-stage read pipeline feeds the registered output under backpressure.
module expansion_video #(
   parameter int WIDTH     = 8,
   parameter int LINE_LEN  = 720,
   parameter int NUM_LINES = 288,
   parameter int ADDR_W    = 10
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              enable,
   input  logic              sof,
   expansion_video_if.slave  vif
);
   localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(LINE_LEN - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_EMIT} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_wpix;
   logic [ADDR_W-1:0] r_rpix;
   logic [LINE_W-1:0] r_line;
   logic              r_wsel;
   logic [1:0]        r_rsub;
   logic [1:0]        w_nsub;

   logic [WIDTH-1:0]  r_buf0 [LINE_LEN];
   logic [WIDTH-1:0]  r_buf1 [LINE_LEN];
   logic [WIDTH-1:0]  r_rd0;
   logic [WIDTH-1:0]  r_rd1;

   logic              r_s1_v;
   logic              r_s1_sel;
   logic              r_s1_avg;
   logic              r_s1_eol;
   logic              r_s1_eof;

   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_pix;
   logic              r_out_eol;
   logic              r_out_eof;

   logic              w_in_ready;
   logic              w_in_xfer;
   logic              w_sof_ok;
   logic              w_wsel_eff;
   logic              w_last_line;
   logic              w_sub_avg;
   logic              w_s2_free;
   logic              w_s1_free;
   logic              w_issue;
   logic              w_last_issue;
   logic [WIDTH-1:0]  w_cur;
   logic [WIDTH-1:0]  w_prv;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_res;

   assign w_in_xfer   = vif.in_valid & w_in_ready & enable;
   assign w_sof_ok    = enable & sof &
                        ((r_state == S_IDLE) || ((r_state == S_WRITE) && (r_wpix == '0)));
   assign w_wsel_eff  = w_sof_ok ? 1'b0 : r_wsel;
   assign w_last_line = (r_line == LAST_LINE);

   // Sub-lines per EMIT: line 0 -> COPY; middle -> AVG,COPY; last -> AVG,COPY,COPY; single line -> COPY,COPY
   always_comb begin
      w_nsub = 2'd2;
      if (NUM_LINES == 1)
         w_nsub = 2'd2;
      else if (r_line == '0)
         w_nsub = 2'd1;
      else if (w_last_line)
         w_nsub = 2'd3;
   end

   assign w_sub_avg    = (r_rsub == 2'd0) && (r_line != '0);
   assign w_s2_free    = enable & (~r_out_valid | vif.out_ready);
   assign w_s1_free    = ~r_s1_v | w_s2_free;
   assign w_issue      = (r_state == S_EMIT) & enable & w_s1_free;
   assign w_last_issue = w_issue && (r_rpix == LAST_PIX) && (r_rsub == w_nsub - 2'd1);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_sof_ok)
               w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            w_in_ready = 1'b1;
            if (w_in_xfer && (r_wpix == LAST_PIX))
               w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (w_last_issue)
               w_state_nxt = w_last_line ? S_IDLE : S_WRITE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_wpix <= '0;
         r_rpix <= '0;
         r_rsub <= '0;
         r_line <= '0;
         r_wsel <= 1'b0;
      end else begin
         if (w_sof_ok) begin
            r_wpix <= '0;
            r_line <= '0;
            r_wsel <= 1'b0;
         end
         if (w_in_xfer)
            r_wpix <= (r_wpix == LAST_PIX) ? '0 : r_wpix + 1'b1;
         if (w_issue) begin
            if (r_rpix == LAST_PIX) begin
               r_rpix <= '0;
               r_rsub <= w_last_issue ? 2'd0 : r_rsub + 2'd1;
            end else begin
               r_rpix <= r_rpix + 1'b1;
            end
         end
         // All reads for this line are issued, so the older buffer is free for the next line
         if (w_last_issue) begin
            r_wsel <= ~r_wsel;
            r_line <= w_last_line ? '0 : r_line + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_in_xfer) begin
         if (w_wsel_eff)
            r_buf1[r_wpix] <= vif.in_pix;
         else
            r_buf0[r_wpix] <= vif.in_pix;
      end
      if (w_issue) begin
         r_rd0 <= r_buf0[r_rpix];
         r_rd1 <= r_buf1[r_rpix];
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_s1_v   <= 1'b0;
         r_s1_sel <= 1'b0;
         r_s1_avg <= 1'b0;
         r_s1_eol <= 1'b0;
         r_s1_eof <= 1'b0;
      end else if (w_issue) begin
         r_s1_v   <= 1'b1;
         r_s1_sel <= r_wsel;
         r_s1_avg <= w_sub_avg;
         r_s1_eol <= (r_rpix == LAST_PIX);
         r_s1_eof <= w_last_issue & w_last_line;
      end else if (w_s2_free) begin
         r_s1_v   <= 1'b0;
      end
   end

   // Current line lives in the buffer selected at issue time; the other holds the previous line
   assign w_cur = r_s1_sel ? r_rd1 : r_rd0;
   assign w_prv = r_s1_sel ? r_rd0 : r_rd1;
   assign w_sum = {1'b0, w_cur} + {1'b0, w_prv};
   assign w_res = r_s1_avg ? w_sum[WIDTH:1] : w_cur;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_pix   <= '0;
         r_out_eol   <= 1'b0;
         r_out_eof   <= 1'b0;
      end else if (w_s2_free) begin
         r_out_valid <= r_s1_v;
         if (r_s1_v)
            r_out_pix <= w_res;
         r_out_eol   <= r_s1_v & r_s1_eol;
         r_out_eof   <= r_s1_v & r_s1_eof;
      end
   end

   assign vif.in_ready  = w_in_ready;
   assign vif.out_valid = r_out_valid;
   assign vif.out_pix   = r_out_pix;
   assign vif.out_eol   = r_out_eol;
   assign vif.out_eof   = r_out_eof;
endmodule

// File: tb/tb_expansion_video.sv
// tb/tb_expansion_video.sv - directed bench for expansion_video (3-line and 1-line frames)
module tb_expansion_video;
   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       sof_a;
   logic       sof_b;
   logic       out_ready;
   logic       in_valid;
   logic [7:0] in_pix;
   logic       rmode;

   int errors = 0;
   int checks = 0;
   int in_xfers = 0;

   logic [9:0] q_a[$];
   logic [9:0] q_b[$];
   logic       stall_prev = 1'b0;
   logic [9:0] prev_out = '0;

   logic [7:0] lines [3][4];
   logic [7:0] exp_a [24] = '{8'd10, 8'd20, 8'd30, 8'd40,  8'd20, 8'd30, 8'd40, 8'd50,
                              8'd30, 8'd40, 8'd50, 8'd61,  8'd142, 8'd147, 8'd25, 8'd31,
                              8'd255, 8'd255, 8'd0, 8'd1,  8'd255, 8'd255, 8'd0, 8'd1};
   logic [7:0] exp_b [8]  = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd7, 8'd8, 8'd9, 8'd10};

   expansion_video_if #(.WIDTH(8)) if_a ();
   expansion_video_if #(.WIDTH(8)) if_b ();

   assign if_a.in_pix    = in_pix;
   assign if_a.in_valid  = in_valid;
   assign if_a.out_ready = out_ready;
   assign if_b.in_pix    = in_pix;
   assign if_b.in_valid  = in_valid;
   assign if_b.out_ready = out_ready;

   expansion_video #(.WIDTH(8), .LINE_LEN(4), .NUM_LINES(3), .ADDR_W(2)) dut_a (
      .clk_in (clk),
      .rst    (rst_n),
      .enable (enable),
      .sof    (sof_a),
      .vif    (if_a.slave)
   );

   expansion_video #(.WIDTH(8), .LINE_LEN(4), .NUM_LINES(1), .ADDR_W(2)) dut_b (
      .clk_in (clk),
      .rst    (rst_n),
      .enable (enable),
      .sof    (sof_b),
      .vif    (if_b.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (enable && if_a.in_valid && if_a.in_ready)
            in_xfers++;
         if (enable && if_a.out_valid && out_ready)
            q_a.push_back({if_a.out_eof, if_a.out_eol, if_a.out_pix});
         if (enable && if_b.out_valid && out_ready)
            q_b.push_back({if_b.out_eof, if_b.out_eol, if_b.out_pix});
         if (stall_prev)
            chk("stall_hold", 32'({if_a.out_valid, if_a.out_eof, if_a.out_eol, if_a.out_pix}),
                32'({1'b1, prev_out}));
         stall_prev = if_a.out_valid & ~(out_ready & enable);
         prev_out   = {if_a.out_eof, if_a.out_eol, if_a.out_pix};
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic send_pix(input logic bsel, input logic [7:0] v);
      int  n;
      logic acc;
      in_pix   = v;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         acc = enable & (bsel ? if_b.in_ready : if_a.in_ready);
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 300);
      if (!acc)
         chk("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic pulse_sof(input logic bsel);
      if (bsel) sof_b = 1'b1; else sof_a = 1'b1;
      @(posedge clk);
      #1;
      sof_a = 1'b0;
      sof_b = 1'b0;
   endtask

   task automatic send_line(input int l);
      for (int p = 0; p < 4; p++)
         send_pix(1'b0, lines[l][p]);
   endtask

   task automatic check_frame_a(input string tag);
      int n;
      n = 0;
      while (q_a.size() < 24 && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (10) @(posedge clk);
      #1;
      chk({tag, "_count"}, 32'(q_a.size()), 32'd24);
      if (q_a.size() >= 24)
         for (int i = 0; i < 24; i++)
            chk(tag, 32'(q_a[i]), 32'({(i == 23), (i % 4 == 3), exp_a[i]}));
      q_a.delete();
   endtask

   initial begin
      lines = '{'{8'd10, 8'd20, 8'd30, 8'd40},
                '{8'd30, 8'd40, 8'd50, 8'd61},
                '{8'd255, 8'd255, 8'd0, 8'd1}};
      rst_n    = 1'b0;
      enable   = 1'b1;
      sof_a    = 1'b0;
      sof_b    = 1'b0;
      in_valid = 1'b0;
      in_pix   = '0;
      rmode    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(if_a.in_ready),  32'd0);
      chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
      chk("rst_out_pix",   32'(if_a.out_pix),   32'd0);
      chk("rst_out_eol",   32'(if_a.out_eol),   32'd0);
      chk("rst_out_eof",   32'(if_a.out_eof),   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame 1: out_ready high, in_valid held high across the whole frame
      in_xfers = 0;
      pulse_sof(1'b0);
      for (int l = 0; l < 3; l++)
         send_line(l);
      check_frame_a("f1_ready");
      chk("f1_in_xfers", 32'(in_xfers), 32'd12);
      in_valid = 1'b0;

      // Frame 2: random backpressure
      rmode = 1'b1;
      pulse_sof(1'b0);
      for (int l = 0; l < 3; l++)
         send_line(l);
      in_valid = 1'b0;
      check_frame_a("f2_random");
      rmode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Frame 3: enable low mid-WRITE and mid-EMIT, plus an ignored mid-line sof
      pulse_sof(1'b0);
      send_pix(1'b0, lines[0][0]);
      send_pix(1'b0, lines[0][1]);
      enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b1;
      send_pix(1'b0, lines[0][2]);
      send_pix(1'b0, lines[0][3]);
      send_pix(1'b0, lines[1][0]);
      send_pix(1'b0, lines[1][1]);
      in_valid = 1'b0;
      pulse_sof(1'b0);
      send_pix(1'b0, lines[1][2]);
      send_pix(1'b0, lines[1][3]);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b1;
      send_line(2);
      in_valid = 1'b0;
      check_frame_a("f3_enable");

      // Frame 4: reset during the second pixel of AVG(L0,L1), then a clean frame
      pulse_sof(1'b0);
      send_line(0);
      send_line(1);
      in_valid = 1'b0;
      begin
         int n;
         n = 0;
         while (q_a.size() < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("avg2_valid", 32'(if_a.out_valid), 32'd1);
      chk("avg2_pix",   32'(if_a.out_pix),   32'd30);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  32'(if_a.in_ready),  32'd0);
      chk("mid_rst_out_valid", 32'(if_a.out_valid), 32'd0);
      chk("mid_rst_out_pix",   32'(if_a.out_pix),   32'd0);
      chk("mid_rst_out_eol",   32'(if_a.out_eol),   32'd0);
      chk("mid_rst_out_eof",   32'(if_a.out_eof),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_a.delete();
      @(posedge clk);
      #1;
      pulse_sof(1'b0);
      for (int l = 0; l < 3; l++)
         send_line(l);
      in_valid = 1'b0;
      check_frame_a("f4_after_rst");

      // Single-line frame on the NUM_LINES=1 instance
      pulse_sof(1'b1);
      send_pix(1'b1, 8'd7);
      send_pix(1'b1, 8'd8);
      send_pix(1'b1, 8'd9);
      send_pix(1'b1, 8'd10);
      in_valid = 1'b0;
      begin
         int n;
         n = 0;
         while (q_b.size() < 8 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      repeat (10) @(posedge clk);
      #1;
      chk("one_line_count", 32'(q_b.size()), 32'd8);
      if (q_b.size() >= 8)
         for (int i = 0; i < 8; i++)
            chk("one_line", 32'(q_b[i]), 32'({(i == 7), (i % 4 == 3), exp_b[i]}));
      chk("a_idle_no_output", 32'(q_a.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
